// File: rtl/ours_test_io_to_xs.sv
// ours_test_io_to_xs: responder (target) end of the two-wire test_io link.
//
// Request frames arrive serially on the E/D pins (ein qualifies din, MSB
// first) as op[1:0], addr, then data for writes. A good frame becomes one
// parallel valid/ready request toward an on-chip slave. The acknowledge or
// the read data goes back serially on the D pin after a turnaround gap:
// start bit 1, status bit (0 ok / 1 error), then read data MSB first.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   test_io_ein, test_io_din   frame enable and serial request bit
//   test_io_eoen, test_io_eout E pin is input-only: enable tied off, data 0
//   test_io_doen, test_io_dout D pin enable (active low) and response bit
//   req_vld/req_rdy/req_we/req_addr/req_wdata  parallel request
//   rsp_vld/rsp_rdy/rsp_data   read data return
//   err_cnt                    saturating count of dropped/bad frames
//
// Optional feature macro: TEST_IO_PARITY_EN
//   Defined: the request carries a trailing even-parity bit over
//   op/addr/data (mismatch answers with status 1), and the response ends
//   with an even-parity bit over status and data.
module ours_test_io_to_xs #(
    parameter int TEST_IO_ADDR_W = 40,
    parameter int TEST_IO_DATA_W = 64,
    parameter int TURNAROUND_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      test_io_ein,
    input  logic                      test_io_din,
    output logic                      test_io_eoen,
    output logic                      test_io_eout,
    output logic                      test_io_doen,
    output logic                      test_io_dout,
    output logic                      req_vld,
    input  logic                      req_rdy,
    output logic                      req_we,
    output logic [TEST_IO_ADDR_W-1:0] req_addr,
    output logic [TEST_IO_DATA_W-1:0] req_wdata,
    input  logic                      rsp_vld,
    output logic                      rsp_rdy,
    input  logic [TEST_IO_DATA_W-1:0] rsp_data,
    output logic [7:0]                err_cnt
);

`ifdef TEST_IO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int WR_LEN    = 2 + TEST_IO_ADDR_W + TEST_IO_DATA_W;
    localparam int RD_LEN    = 2 + TEST_IO_DATA_W;
    localparam int FRAME_MAX = ((WR_LEN > RD_LEN) ? WR_LEN : RD_LEN) + PAR_BITS;
    localparam int CNT_W     = $clog2(FRAME_MAX + 1);
    localparam int TX_W      = 2 + TEST_IO_DATA_W + PAR_BITS;

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(TEST_IO_ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(TEST_IO_DATA_W - 1);
    localparam logic [CNT_W-1:0] TA_LAST    = CNT_W'(TURNAROUND_CYC - 1);
    localparam logic [CNT_W-1:0] TX_LAST_SH = CNT_W'(1 + PAR_BITS);
    localparam logic [CNT_W-1:0] TX_LAST_RD = CNT_W'(1 + TEST_IO_DATA_W + PAR_BITS);

    typedef enum logic [3:0] {
        IDLE, RX_OP, RX_ADDR, RX_DATA, RX_PAR, WAIT_END, REQ, RSP_WAIT, TA, TX
    } state_t;

`ifdef TEST_IO_PARITY_EN
    localparam state_t FIELDS_DONE = RX_PAR;
`else
    localparam state_t FIELDS_DONE = WAIT_END;
`endif

    state_t            state;
    state_t            state_next;
    logic              ein_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op;
    logic              par_acc;
    logic              rd_ok;
    logic [TX_W-1:0]   tx_sr;
    logic              err_inc;
    logic              ein_rise;
    logic              is_write;
    logic              frame_err;
    logic [CNT_W-1:0]  tx_last;

    // Frames only start on a rising ein. ein_q resets to 1 so a frame
    // already in flight at reset release, or one that began while busy,
    // is never picked up halfway through.
    assign ein_rise = test_io_ein & ~ein_q;
    assign is_write = (op == 2'b01);
    assign tx_last  = rd_ok ? TX_LAST_RD : TX_LAST_SH;

`ifdef TEST_IO_PARITY_EN
    // par_acc also folds in the received parity bit, so 1 means a mismatch.
    assign frame_err = op[1] | par_acc;
`else
    assign frame_err = op[1];
`endif

    assign test_io_eoen = 1'b1;
    assign test_io_eout = 1'b0;
    assign test_io_doen = (state != TX);
    assign test_io_dout = (state == TX) ? tx_sr[TX_W-1] : 1'b0;
    assign req_vld      = (state == REQ);
    assign rsp_rdy      = (state == RSP_WAIT);
    assign req_we       = is_write;

    // Response word, left-aligned: start, status, data, optional parity.
    function automatic logic [TX_W-1:0] tx_word(input logic status,
                                                input logic [TEST_IO_DATA_W-1:0] data);
`ifdef TEST_IO_PARITY_EN
        return {1'b1, status, data, status ^ (^data)};
`else
        return {1'b1, status, data};
`endif
    endfunction

    // Next-state and error-event decode.
    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (ein_rise) state_next = RX_OP;
            end
            RX_OP: begin
                if (!test_io_ein) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end else begin
                    state_next = RX_ADDR;
                end
            end
            RX_ADDR: begin
                if (!test_io_ein) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end else if (cnt == ADDR_LAST) begin
                    state_next = is_write ? RX_DATA : FIELDS_DONE;
                end
            end
            RX_DATA: begin
                if (!test_io_ein) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end else if (cnt == DATA_LAST) begin
                    state_next = FIELDS_DONE;
                end
            end
            RX_PAR: begin
                if (!test_io_ein) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end else begin
                    state_next = WAIT_END;
                end
            end
            WAIT_END: begin
                if (!test_io_ein) begin
                    if (frame_err) begin
                        state_next = TA;
                        err_inc    = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (req_rdy) state_next = is_write ? TA : RSP_WAIT;
            end
            RSP_WAIT: begin
                if (rsp_vld) state_next = TA;
            end
            TA: begin
                if (cnt == TA_LAST) state_next = TX;
            end
            TX: begin
                if (cnt == tx_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A frame started while busy is a protocol violation, counted once.
        if (ein_rise && (state inside {REQ, RSP_WAIT, TA, TX})) err_inc = 1'b1;
    end

    // State register plus the deserializer, response loader and shifter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ein_q     <= 1'b1;
            cnt       <= '0;
            op        <= 2'b00;
            par_acc   <= 1'b0;
            rd_ok     <= 1'b0;
            tx_sr     <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            err_cnt   <= 8'd0;
        end else begin
            state <= state_next;
            ein_q <= test_io_ein;
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (ein_rise) begin
                        op      <= {1'b0, test_io_din};
                        par_acc <= test_io_din;
                        cnt     <= '0;
                    end
                end
                RX_OP: begin
                    if (test_io_ein) begin
                        op      <= {op[0], test_io_din};
                        par_acc <= par_acc ^ test_io_din;
                    end
                end
                RX_ADDR: begin
                    if (test_io_ein) begin
                        req_addr <= {req_addr[TEST_IO_ADDR_W-2:0], test_io_din};
                        par_acc  <= par_acc ^ test_io_din;
                        cnt      <= (cnt == ADDR_LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (test_io_ein) begin
                        req_wdata <= {req_wdata[TEST_IO_DATA_W-2:0], test_io_din};
                        par_acc   <= par_acc ^ test_io_din;
                        cnt       <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end
                RX_PAR: begin
                    if (test_io_ein) par_acc <= par_acc ^ test_io_din;
                end
                WAIT_END: begin
                    if (!test_io_ein && frame_err) begin
                        tx_sr <= tx_word(1'b1, '0);
                        rd_ok <= 1'b0;
                        cnt   <= '0;
                    end
                end
                REQ: begin
                    if (req_rdy && is_write) begin
                        tx_sr <= tx_word(1'b0, '0);
                        rd_ok <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RSP_WAIT: begin
                    if (rsp_vld) begin
                        tx_sr <= tx_word(1'b0, rsp_data);
                        rd_ok <= 1'b1;
                        cnt   <= '0;
                    end
                end
                TA: begin
                    cnt <= (cnt == TA_LAST) ? '0 : cnt + CNT_W'(1);
                end
                TX: begin
                    tx_sr <= tx_sr << 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ours_test_io_to_xs.sv
// tb_ours_test_io_to_xs: table-driven bench for ours_test_io_to_xs.
// Each table row is one request frame plus the handshake timing to apply
// and the hand-computed outcome; a few hand-written sequences cover reset.
module tb_ours_test_io_to_xs;

    localparam int A  = 40;
    localparam int D  = 64;
    localparam int TA = 2;
`ifdef TEST_IO_PARITY_EN
    localparam int P    = 1;
    localparam int NVEC = 11;
`else
    localparam int P    = 0;
    localparam int NVEC = 10;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         ein;
    logic         din;
    logic         eoen;
    logic         eout;
    logic         doen;
    logic         dout;
    logic         req_vld;
    logic         req_rdy;
    logic         req_we;
    logic [A-1:0] req_addr;
    logic [D-1:0] req_wdata;
    logic         rsp_vld;
    logic         rsp_rdy;
    logic [D-1:0] rsp_data;
    logic [7:0]   err_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]   op;
        logic [A-1:0] addr;
        logic [D-1:0] data;
        logic [D-1:0] rdata;
        int           short_len;
        int           extra;
        int           rdy_dly;
        int           rsp_dly;
        int           viol_at;
        int           viol_len;
        bit           bad_par;
        bit           exp_req;
        bit           exp_status;
        bit           exp_rsp;
        int           exp_err;
    } vec_t;

    vec_t vecs [11];
    vec_t fin;

    always #5 clk = ~clk;

    ours_test_io_to_xs #(
        .TEST_IO_ADDR_W(A),
        .TEST_IO_DATA_W(D),
        .TURNAROUND_CYC(TA)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .test_io_ein (ein),
        .test_io_din (din),
        .test_io_eoen(eoen),
        .test_io_eout(eout),
        .test_io_doen(doen),
        .test_io_dout(dout),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_data    (rsp_data),
        .err_cnt     (err_cnt)
    );

    task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int fullLen(input vec_t v);
        return 2 + A + ((v.op == 2'b01) ? D : 0) + P;
    endfunction

    // Bit i of the serial frame: fields, optional parity, then filler.
    function automatic logic getBit(input vec_t v, input int i);
        int full;
        full = fullLen(v);
        if (i < 2) return v.op[1-i];
        if (i < 2 + A) return v.addr[A-1-(i-2)];
        if (v.op == 2'b01 && i < 2 + A + D) return v.data[D-1-(i-2-A)];
`ifdef TEST_IO_PARITY_EN
        if (i == full - 1)
            return (^v.op) ^ (^v.addr) ^ ((v.op == 2'b01) ? (^v.data) : 1'b0) ^ v.bad_par;
`endif
        return i[0];
    endfunction

    task automatic applyStimulus(input vec_t v);
        int n;
        n = (v.short_len > 0) ? v.short_len : fullLen(v) + v.extra;
        req_rdy  = 1'b0;
        rsp_vld  = 1'b0;
        rsp_data = v.rdata;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ein = 1'b1;
            din = getBit(v, i);
        end
        @(negedge clk);
        ein = 1'b0;
        din = 1'b0;
    endtask

    // Entered on the negedge where ein fell (t = 0). Plays the slave side
    // and records what appears on the pins until the response completes.
    task automatic checkOutput(input int idx, input vec_t v);
        int           t;
        bit           done;
        bit           is_rd;
        int           req_cycles;
        int           rsp_cycles;
        int           tx_cnt;
        int           tx_first;
        int           field_errs;
        int           exp_len;
        int           exp_t;
        logic [127:0] tx_bits;
        logic [127:0] exp_bits;
        logic         par;
        t = 0; done = 0; req_cycles = 0; rsp_cycles = 0; tx_cnt = 0;
        tx_first = -1; field_errs = 0; tx_bits = '0;
        is_rd = v.exp_req && (v.op == 2'b00);
        while (!done && t < 400) begin
            if (t > 0) @(negedge clk);
            if (v.viol_at > 0) ein = (t >= v.viol_at) && (t < v.viol_at + v.viol_len);
            if (req_vld) begin
                req_cycles++;
                if (req_addr !== v.addr || req_we !== (v.op == 2'b01) ||
                    (v.op == 2'b01 && req_wdata !== v.data)) field_errs++;
                req_rdy = (req_cycles > v.rdy_dly);
            end else begin
                req_rdy = 1'b0;
            end
            if (rsp_rdy) begin
                rsp_cycles++;
                rsp_vld = (rsp_cycles > v.rsp_dly);
            end else begin
                rsp_vld = 1'b0;
            end
            if (!doen) begin
                if (tx_cnt == 0) tx_first = t;
                tx_bits = {tx_bits[126:0], dout};
                tx_cnt++;
            end else if (tx_cnt > 0) begin
                done = 1;
            end
            if (!v.exp_rsp && t >= 20) done = 1;
            t++;
        end
        ein = 1'b0;
        req_rdy = 1'b0;
        rsp_vld = 1'b0;

        exp_len  = v.exp_rsp ? ((is_rd ? 2 + D : 2) + P) : 0;
        exp_t    = 1 + TA + (v.exp_req ? 1 + v.rdy_dly : 0) + (is_rd ? 1 + v.rsp_dly : 0);
        exp_bits = '0;
        if (v.exp_rsp) begin
            exp_bits = {1'b1, v.exp_status};
            par = v.exp_status;
            if (is_rd) begin
                exp_bits = {exp_bits[127-D:0], v.rdata};
                par = par ^ (^v.rdata);
            end
            if (P == 1) exp_bits = {exp_bits[126:0], par};
        end

        checkValue($sformatf("v%0d_done", idx), done, 1'b1);
        checkValue($sformatf("v%0d_req_cycles", idx), req_cycles, v.exp_req ? v.rdy_dly + 1 : 0);
        if (v.exp_req) checkValue($sformatf("v%0d_req_fields", idx), field_errs, 0);
        checkValue($sformatf("v%0d_rsp_rdy_cycles", idx), rsp_cycles, is_rd ? v.rsp_dly + 1 : 0);
        checkValue($sformatf("v%0d_tx_len", idx), tx_cnt, exp_len);
        if (v.exp_rsp) checkValue($sformatf("v%0d_tx_start", idx), tx_first, exp_t);
        checkValue($sformatf("v%0d_tx_bits", idx), tx_bits, exp_bits);
        checkValue($sformatf("v%0d_err_cnt", idx), err_cnt, v.exp_err);
    endtask

    initial begin
        //        op     addr               data                   rdata                  sh ex rdy rsp va vl bp rq st rs err
        vecs[0] = '{2'b01, 40'h12_3456_789A, 64'hDEAD_BEEF_0123_4567, 64'h0,                 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        vecs[1] = '{2'b00, 40'h40,           64'h0,                 64'hA5A5_0000_FFFF_1234, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0};
        vecs[2] = '{2'b10, 40'h55,           64'h0,                 64'h0,                 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[3] = '{2'b01, 40'h12_3456_789A, 64'h1111,              64'h0,                20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        vecs[4] = '{2'b00, 40'hFF_FFFF_FFFF, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 2};
        vecs[5] = '{2'b01, 40'h0,            64'hFFFF_FFFF_FFFF_FFFF, 64'h0,               0, 0,10, 0, 0, 0, 0, 1, 0, 1, 2};
        vecs[6] = '{2'b11, 40'h1,            64'h0,                 64'h0,                 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3};
        vecs[7] = '{2'b01, 40'h0,            64'h0,                 64'h0,                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};
        vecs[8] = '{2'b01, 40'hA_BCDE,       64'h1,                 64'h0,                 0, 0, 4, 0, 2, 3, 0, 1, 0, 1, 5};
        vecs[9] = '{2'b00, 40'h7,            64'h0,                 64'h8000_0000_0000_0001, 0, 0, 0, 1,11,10, 0, 1, 0, 1, 6};
        vecs[10] = '{2'b01, 40'h3C,          64'h5A,                64'h0,                 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 7};
        fin      = '{2'b01, 40'h99_8877_6655, 64'h0F0F_1234_5678_9ABC, 64'h0,              0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};

        // Reset values, with ein already high when reset is released.
        rstn = 1'b0; ein = 1'b1; din = 1'b0;
        req_rdy = 1'b0; rsp_vld = 1'b0; rsp_data = '0;
        repeat (3) @(negedge clk);
        checkValue("reset_outputs",
                   {eoen, eout, doen, dout, req_vld, rsp_rdy, req_we, req_addr, req_wdata, err_cnt},
                   {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 64'h0, 8'h0});
        begin
            int bad;
            bad = 0;
            rstn = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                din = ~din;
                if (req_vld || !doen) bad++;
            end
            ein = 1'b0;
            din = 1'b0;
            repeat (3) @(negedge clk);
            checkValue("ein_high_after_reset_activity", bad, 0);
            checkValue("ein_high_after_reset_err_cnt", err_cnt, 8'h0);
        end

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Reset in the middle of a read response.
        begin
            int n;
            applyStimulus(vecs[1]);
            req_rdy  = 1'b1;
            rsp_vld  = 1'b1;
            rsp_data = 64'hFEDC_BA98_7654_3210;
            n = 0;
            while (doen && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkValue("rst_tx_started", doen, 1'b0);
            repeat (10) @(negedge clk);
            rstn = 1'b0;
            #1;
            checkValue("rst_mid_tx", {doen, dout, req_vld, rsp_rdy, err_cnt},
                       {1'b1, 1'b0, 1'b0, 1'b0, 8'h0});
            req_rdy = 1'b0;
            rsp_vld = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            applyStimulus(fin);
            checkOutput(99, fin);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
